contador_digito: RTL and testbench

- Upstream stage of the 7-segment decoder. Turns two push-buttons (increment/decrement) into a debounced, wrapping 4-bit digit value.
- The value drives the decoder's A, B, C, D inputs directly; A is the MSB and D is the LSB.
- Also produces single-cycle carry/borrow pulses so further digits can be chained.

---
 rtl/contador_pkg.sv | 24 ++
 rtl/debounce_botao.sv | 62 ++++++
 rtl/contador_digito.sv | 105 ++++++++++
 tb/tb_contador_digito.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared types and helpers for the contador_digito slice.
//   DIGIT_W  : width of the digit value (drives decoder inputs A..D)
//   digito_t : 4-bit unsigned digit value
//   op_t     : count operation selected for one clock edge
//   deb_w()  : width of a debounce counter that must hold 0..n-1
package contador_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digito_t;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2
  } op_t;

  function automatic int deb_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Per-button conditioning: 2-flop synchroniser, stable-level debouncer and
// rising-edge detector producing a one-cycle press pulse.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   raw   : raw asynchronous button level (high = pressed)
//   pulse : one-cycle pulse per accepted press
module debounce_botao
  import contador_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CW = deb_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic          deb_prev_q, deb_prev_d;

  always_comb begin
    s1_d       = raw;
    s2_d       = s1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    cnt_d      = cnt_q;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // s2 has now differed from deb for DEB_CYCLES consecutive cycles
      deb_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
    end
  end

  assign pulse = deb_q & ~deb_prev_q;

endmodule

// File: rtl/contador_digito.sv
// Debounced up/down digit counter feeding a 7-segment decoder.
//   clk, rst_n       : clock, asynchronous active-low reset
//   btn_inc, btn_dec : raw push-buttons (high = pressed)
//   en               : count enable; presses while low are discarded
//   A, B, C, D       : registered digit value, A = MSB, D = LSB
//   carry, borrow    : one-cycle pulses on wrap MAX_VAL->0 / 0->MAX_VAL
// Build option: define CONTADOR_SATURA_EN to saturate at 0 / MAX_VAL instead
// of wrapping; carry and borrow are then held at 0.
module contador_digito
  import contador_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int MAX_VAL    = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_inc,
  input  logic btn_dec,
  input  logic en,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic carry,
  output logic borrow
);

  localparam digito_t MAX_D = digito_t'(MAX_VAL);

  logic    inc_pulse, dec_pulse;
  op_t     op;
  digito_t value_q, value_d;
  logic    carry_q, carry_d;
  logic    borrow_q, borrow_d;

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_inc),
    .pulse (inc_pulse)
  );

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_dec),
    .pulse (dec_pulse)
  );

  always_comb begin
    op = OP_HOLD;
    if (en && inc_pulse && !dec_pulse) op = OP_INC;
    else if (en && dec_pulse && !inc_pulse) op = OP_DEC;
  end

  always_comb begin
    value_d  = value_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    case (op)
      OP_INC: begin
        if (value_q >= MAX_D) begin
`ifdef CONTADOR_SATURA_EN
          value_d = MAX_D;
`else
          value_d = '0;
          carry_d = 1'b1;
`endif
        end else begin
          value_d = value_q + 4'd1;
        end
      end
      OP_DEC: begin
        if (value_q == '0) begin
`ifdef CONTADOR_SATURA_EN
          value_d  = '0;
`else
          value_d  = MAX_D;
          borrow_d = 1'b1;
`endif
        end else begin
          value_d = value_q - 4'd1;
        end
      end
      default: value_d = value_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign {A, B, C, D} = value_q;
  assign carry        = carry_q;
  assign borrow       = borrow_q;

endmodule

// File: tb/tb_contador_digito.sv
module tb_contador_digito;

  localparam int DEB = 4;
  localparam int MAXV = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_inc = 1'b0;
  logic btn_dec = 1'b0;
  logic en = 1'b1;
  logic A, B, C, D, carry, borrow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  contador_digito #(.DEB_CYCLES(DEB), .MAX_VAL(MAXV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_inc (btn_inc),
    .btn_dec (btn_dec),
    .en      (en),
    .A       (A),
    .B       (B),
    .C       (C),
    .D       (D),
    .carry   (carry),
    .borrow  (borrow)
  );

  // Reference model: a press is accepted when the last DEB pin samples,
  // as seen through the two-stage synchroniser, all differ from the
  // current accepted level; the count changes one edge after acceptance.
  bit hist_i [0:DEB];
  bit hist_d [0:DEB];
  bit mdeb_i, mdeb_d, pend_i, pend_d;
  int m_val;
  bit m_carry, m_borrow;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= DEB; j++) begin hist_i[j] = 0; hist_d[j] = 0; end
      mdeb_i = 0; mdeb_d = 0; pend_i = 0; pend_d = 0;
      m_val = 0; m_carry = 0; m_borrow = 0;
    end else begin
      bit fi, fd, ni, nd;
      m_carry = 0; m_borrow = 0;
      if (en && pend_i && !pend_d) begin
        if (m_val == MAXV) begin
`ifdef CONTADOR_SATURA_EN
          m_val = MAXV;
`else
          m_val = 0; m_carry = 1;
`endif
        end else m_val = m_val + 1;
      end else if (en && pend_d && !pend_i) begin
        if (m_val == 0) begin
`ifdef CONTADOR_SATURA_EN
          m_val = 0;
`else
          m_val = MAXV; m_borrow = 1;
`endif
        end else m_val = m_val - 1;
      end
      fi = 1; fd = 1;
      for (int j = 1; j <= DEB; j++) begin
        if (hist_i[j] == mdeb_i) fi = 0;
        if (hist_d[j] == mdeb_d) fd = 0;
      end
      ni = fi && !mdeb_i;
      nd = fd && !mdeb_d;
      if (fi) mdeb_i = !mdeb_i;
      if (fd) mdeb_d = !mdeb_d;
      pend_i = ni; pend_d = nd;
      for (int j = DEB; j >= 1; j--) begin
        hist_i[j] = hist_i[j-1];
        hist_d[j] = hist_d[j-1];
      end
      hist_i[0] = btn_inc;
      hist_d[0] = btn_dec;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_value", {28'd0, A, B, C, D}, m_val);
    chk("model_carry", {31'd0, carry}, {31'd0, m_carry});
    chk("model_borrow", {31'd0, borrow}, {31'd0, m_borrow});
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Press starting at a negedge; edge 0 is the next posedge, the digit
  // must change at edge DEB+2 and any wrap pulse must last one cycle.
  task automatic press_check(input bit i, input bit d, input int exp_v,
                             input bit exp_c, input bit exp_b, input string nm);
    @(negedge clk); btn_inc = i; btn_dec = d;
    repeat (DEB + 3) @(posedge clk);
    #1;
    chk({nm, "_value"}, {28'd0, A, B, C, D}, exp_v);
    chk({nm, "_carry"}, {31'd0, carry}, {31'd0, exp_c});
    chk({nm, "_borrow"}, {31'd0, borrow}, {31'd0, exp_b});
    @(posedge clk); #1;
    chk({nm, "_carry_end"}, {31'd0, carry}, 32'd0);
    chk({nm, "_borrow_end"}, {31'd0, borrow}, 32'd0);
    repeat (12) @(posedge clk);
    @(negedge clk); btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (DEB + 8) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ri, rd;
    // Reset held with both buttons pressed.
    btn_inc = 1'b1; btn_dec = 1'b1; en = 1'b1; rst_n = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("reset_value", {28'd0, A, B, C, D}, 32'd0);
      chk("reset_pulses", {30'd0, carry, borrow}, 32'd0);
    end
    // Release with btn_inc still held: a new press once debounced.
    @(negedge clk); rst_n = 1'b1; btn_dec = 1'b0;
    repeat (DEB + 2) @(posedge clk); #1;
    chk("rel_edge5", {28'd0, A, B, C, D}, 32'd0);
    @(posedge clk); #1;
    chk("rel_edge6", {28'd0, A, B, C, D}, 32'd1);
    repeat (14) @(posedge clk);
    @(negedge clk); btn_inc = 1'b0;
    repeat (15) @(posedge clk); #1;
    chk("rel_hold_one", {28'd0, A, B, C, D}, 32'd1);

    // Glitch shorter than the debounce window.
    @(negedge clk); btn_inc = 1'b1;
    repeat (3) @(negedge clk); btn_inc = 1'b0;
    repeat (15) @(posedge clk); #1;
    chk("glitch", {28'd0, A, B, C, D}, 32'd1);

    // Up-wrap from 0.
    do_reset();
    for (int k = 1; k <= 9; k++) press_check(1, 0, k, 0, 0, "up");
`ifdef CONTADOR_SATURA_EN
    press_check(1, 0, 9, 0, 0, "up_sat");
`else
    press_check(1, 0, 0, 1, 0, "up_wrap");
`endif

    // Down-wrap from 0.
    do_reset();
`ifdef CONTADOR_SATURA_EN
    press_check(0, 1, 0, 0, 0, "down_sat");
`else
    press_check(0, 1, 9, 0, 1, "down_wrap");
`endif

    // Contention at 3, then enable.
    do_reset();
    for (int k = 1; k <= 3; k++) press_check(1, 0, k, 0, 0, "to3");
    press_check(1, 1, 3, 0, 0, "both");
    en = 1'b0;
    press_check(1, 0, 3, 0, 0, "en_off");
    en = 1'b1;
    press_check(1, 0, 4, 0, 0, "en_on");
    press_check(0, 1, 3, 0, 0, "dec");

    // Randomised phase; the model compare process does the checking.
    ri = 0; rd = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (ri == 0) begin btn_inc = 1'($urandom_range(0, 1)); ri = $urandom_range(1, 12); end
      if (rd == 0) begin btn_dec = 1'($urandom_range(0, 1)); rd = $urandom_range(1, 12); end
      ri--; rd--;
      en = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 599) != 0);
    end
    @(negedge clk); rst_n = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
